// File: rtl/agc_gain_apply_if.sv
// Sample, power-measurement and status bundle of the AGC gain actuator.
// The master drives samples and loop controls; the slave returns scaled lanes and loop status.
interface agc_gain_apply_if #(
   parameter int DIN_WIDTH  = 8,
   parameter int PARALLEL   = 8,
   parameter int GAIN_WIDTH = 16
);
   logic [DIN_WIDTH*PARALLEL-1:0] din;
   logic                          din_valid;
   logic [2*DIN_WIDTH-1:0]        pow_in;
   logic                          pow_valid;
   logic [2*DIN_WIDTH-1:0]        ref_pow;
   logic [2*DIN_WIDTH-1:0]        tolerance;
   logic                          enable;
   logic [DIN_WIDTH*PARALLEL-1:0] dout;
   logic                          dout_valid;
   logic [GAIN_WIDTH-1:0]         gain;
   logic                          locked;
   logic                          sat_flag;

   modport master (
      output din, din_valid, pow_in, pow_valid, ref_pow, tolerance, enable,
      input  dout, dout_valid, gain, locked, sat_flag
   );

   modport slave (
      input  din, din_valid, pow_in, pow_valid, ref_pow, tolerance, enable,
      output dout, dout_valid, gain, locked, sat_flag
   );
endinterface

// File: rtl/agc_gain_apply.sv
// AGC actuator: scales parallel signed lanes by a loop gain with saturation, and steps
// that gain toward a reference power using the downstream power measurement.
module agc_gain_apply #(
   parameter int DIN_WIDTH    = 8,
   parameter int PARALLEL     = 8,
   parameter int GAIN_WIDTH   = 16,
   parameter int GAIN_POINT   = 8,
   parameter int GAIN_INIT    = 256,
   parameter int GAIN_MIN     = 16,
   parameter int GAIN_MAX     = 4096,
   parameter int STEP_SHIFT   = 4,
   parameter int SETTLE_BEATS = 32
) (
   input logic          clk,
   input logic          rst,
   agc_gain_apply_if.slave bus
);

   localparam int PW     = 2 * DIN_WIDTH;
   localparam int EW     = PW + 1;
   localparam int PROD_W = DIN_WIDTH + GAIN_WIDTH + 1;
   localparam int SUM_W  = GAIN_WIDTH + 2;
   localparam int CNT_W  = $clog2(SETTLE_BEATS + 1);
   localparam int DW     = DIN_WIDTH * PARALLEL;

   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (DIN_WIDTH - 1) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (DIN_WIDTH - 1)));
   localparam logic signed [SUM_W-1:0]  GMIN_S  = SUM_W'(GAIN_MIN);
   localparam logic signed [SUM_W-1:0]  GMAX_S  = SUM_W'(GAIN_MAX);

   typedef enum logic [1:0] {IDLE, WAIT_POW, UPDATE, SETTLE} state_t;

   // ---------------------------------------------------------------- loop state
   state_t                state, state_next;
   logic [GAIN_WIDTH-1:0] gain_r, gain_next;
   logic                  locked_r, locked_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [PW-1:0]         pow_lat, pow_lat_next;

   logic signed [EW-1:0]    err, abs_err, delta_shift, delta;
   logic signed [SUM_W-1:0] gain_sum;
   logic [GAIN_WIDTH-1:0]   gain_clamped;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         gain_r   <= GAIN_WIDTH'(GAIN_INIT);
         locked_r <= 1'b0;
         cnt      <= '0;
         pow_lat  <= '0;
      end else begin
         state    <= state_next;
         gain_r   <= gain_next;
         locked_r <= locked_next;
         cnt      <= cnt_next;
         pow_lat  <= pow_lat_next;
      end
   end

   always_comb begin
      err         = $signed({1'b0, bus.ref_pow}) - $signed({1'b0, pow_lat});
      abs_err     = err[EW-1] ? -err : err;
      delta_shift = err >>> STEP_SHIFT;
      // A small error still moves the gain by one LSB so the loop cannot stall short of the window.
      if (delta_shift == '0) delta = err[EW-1] ? '1 : EW'(1);
      else                   delta = delta_shift;
      gain_sum = $signed({2'b00, gain_r}) + SUM_W'(delta);
      if (gain_sum < GMIN_S)      gain_clamped = GAIN_WIDTH'(GAIN_MIN);
      else if (gain_sum > GMAX_S) gain_clamped = GAIN_WIDTH'(GAIN_MAX);
      else                        gain_clamped = gain_sum[GAIN_WIDTH-1:0];
   end

   // NOTE: every next-state value gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_next   = state;
      gain_next    = gain_r;
      locked_next  = locked_r;
      cnt_next     = cnt;
      pow_lat_next = pow_lat;
      case (state)
         IDLE: begin
            if (bus.enable) state_next = WAIT_POW;
         end
         WAIT_POW: begin
            if (bus.pow_valid) begin
               pow_lat_next = bus.pow_in;
               state_next   = UPDATE;
            end
         end
         UPDATE: begin
            if (abs_err <= $signed({1'b0, bus.tolerance})) begin
               locked_next = 1'b1;
               state_next  = WAIT_POW;
            end else begin
               locked_next = 1'b0;
               gain_next   = gain_clamped;
               state_next  = SETTLE;
            end
         end
         SETTLE: begin
            if (bus.din_valid) begin
               if (cnt == CNT_W'(SETTLE_BEATS - 1)) begin
                  cnt_next   = '0;
                  state_next = WAIT_POW;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // Disabling the loop wins over everything, including a coincident measurement.
      if (!bus.enable) begin
         state_next  = IDLE;
         gain_next   = gain_r;
         locked_next = 1'b0;
         cnt_next    = '0;
      end
   end

   // ---------------------------------------------------------------- datapath
   logic [DW-1:0]              s1_din;
   logic [GAIN_WIDTH-1:0]      s1_gain;
   logic                       s1_valid, s2_valid;
   logic signed [PROD_W-1:0]   s2_prod [PARALLEL];
   logic signed [PROD_W-1:0]   lane_x  [PARALLEL];
   logic signed [PROD_W-1:0]   gain_x;
   logic signed [PROD_W-1:0]   shifted [PARALLEL];
   logic [DW-1:0]              sat_dout;
   logic [PARALLEL-1:0]        lane_sat;
   logic [DW-1:0]              dout_r;
   logic                       dout_valid_r, sat_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         dout_valid_r <= 1'b0;
         dout_r       <= '0;
         sat_r        <= 1'b0;
      end else begin
         s1_valid     <= bus.din_valid;
         s2_valid     <= s1_valid;
         dout_valid_r <= s2_valid;
         if (s2_valid) begin
            dout_r <= sat_dout;
            sat_r  <= |lane_sat;
         end
      end
   end

   // NOTE: pure data stages carry no reset; their contents are qualified by the reset valid chain.
   always_ff @(posedge clk) begin
      s1_din  <= bus.din;
      s1_gain <= gain_r;
      for (int i = 0; i < PARALLEL; i++) s2_prod[i] <= lane_x[i] * gain_x;
   end

   always_comb begin
      gain_x = PROD_W'($signed({1'b0, s1_gain}));
      for (int i = 0; i < PARALLEL; i++)
         lane_x[i] = PROD_W'($signed(s1_din[i*DIN_WIDTH +: DIN_WIDTH]));
   end

   always_comb begin
      sat_dout = '0;
      lane_sat = '0;
      for (int i = 0; i < PARALLEL; i++) begin
         shifted[i] = s2_prod[i] >>> GAIN_POINT;
         if (shifted[i] > SAT_MAX) begin
            shifted[i]  = SAT_MAX;
            lane_sat[i] = 1'b1;
         end else if (shifted[i] < SAT_MIN) begin
            shifted[i]  = SAT_MIN;
            lane_sat[i] = 1'b1;
         end
         sat_dout[i*DIN_WIDTH +: DIN_WIDTH] = shifted[i][DIN_WIDTH-1:0];
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.sat_flag   = sat_r;
   assign bus.gain       = gain_r;
   assign bus.locked     = locked_r;

endmodule

// File: tb/tb_agc_gain_apply.sv
// Scoreboard bench for agc_gain_apply: lane results predicted at drive time, compared at dout_valid;
// loop gain/lock checked after each measurement.
module tb_agc_gain_apply;
   localparam int DW  = 8;
   localparam int PAR = 8;
   localparam int GW  = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   agc_gain_apply_if #(.DIN_WIDTH(DW), .PARALLEL(PAR), .GAIN_WIDTH(GW)) bus ();

   agc_gain_apply #(
      .DIN_WIDTH(DW), .PARALLEL(PAR), .GAIN_WIDTH(GW), .GAIN_POINT(8), .GAIN_INIT(256),
      .GAIN_MIN(16), .GAIN_MAX(4096), .STEP_SHIFT(4), .SETTLE_BEATS(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [63:0] dout;
      logic        sat;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_gain = 256;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [63:0] d, input int g,
                                 output logic [63:0] o, output logic s);
      o = '0;
      s = 1'b0;
      for (int i = 0; i < PAR; i++) begin
         int x, q;
         logic [31:0] qb;
         x = int'($signed(d[i*DW +: DW]));
         q = (x * g) >>> 8;
         if (q > 127) begin
            q = 127;
            s = 1'b1;
         end else if (q < -128) begin
            q = -128;
            s = 1'b1;
         end
         qb = q;
         o[i*DW +: DW] = qb[7:0];
      end
   endfunction

   always @(negedge clk) begin
      if (bus.dout_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_dout_valid", 64'(bus.dout_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("dout", bus.dout, e.dout);
            check("sat_flag", 64'(bus.sat_flag), 64'(e.sat));
            check("latency", 64'(cyc), 64'(e.cyc + 3));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] d);
      exp_t e;
      model(d, exp_gain, e.dout, e.sat);
      e.cyc = cyc;
      bus.din       = d;
      bus.din_valid = 1'b1;
      sb.push_back(e);
      step();
      bus.din_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) send_beat({$urandom, $urandom});
   endtask

   task automatic pulse_update(input logic [15:0] p);
      bus.pow_in    = p;
      bus.pow_valid = 1'b1;
      step();
      bus.pow_valid = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.din       = 64'h0102_0304_0506_0708;
      bus.din_valid = 1'b1;
      bus.pow_in    = '0;
      bus.pow_valid = 1'b0;
      bus.ref_pow   = 16'd1000;
      bus.tolerance = 16'd50;
      bus.enable    = 1'b0;

      // Reset held with valid input beats
      repeat (4) begin
         step();
         check("rst_dout", bus.dout, 64'd0);
         check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
         check("rst_sat", 64'(bus.sat_flag), 64'd0);
         check("rst_gain", 64'(bus.gain), 64'd256);
         check("rst_locked", 64'(bus.locked), 64'd0);
      end
      rst = 1'b1;
      send_beat(64'h1122_3344_55AA_BBCC);

      // Unity passthrough with loop disabled; a measurement must not move the gain
      send_beat({8'h40, 8'hFB, 8'h05, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'h80});
      settle(4);
      pulse_update(16'd100);
      check("disabled_gain", 64'(bus.gain), 64'd256);
      check("disabled_locked", 64'(bus.locked), 64'd0);
      repeat (4) step();

      // Step up: err=800 -> delta=50
      bus.enable = 1'b1;
      step();
      pulse_update(16'd200);
      check("gain_up", 64'(bus.gain), 64'd306);
      check("locked_after_up", 64'(bus.locked), 64'd0);
      exp_gain = 306;
      bus.pow_in    = 16'd0;
      bus.pow_valid = 1'b1;
      settle(32);
      bus.pow_valid = 1'b0;
      check("settle_ignores_pow", 64'(bus.gain), 64'd306);
      pulse_update(16'd980);
      check("lock_gain", 64'(bus.gain), 64'd306);
      check("lock_flag", 64'(bus.locked), 64'd1);

      // Enable falling together with a measurement: measurement dropped, lock cleared
      bus.enable    = 1'b0;
      bus.pow_in    = 16'd2000;
      bus.pow_valid = 1'b1;
      step();
      bus.pow_valid = 1'b0;
      step();
      check("disable_locked", 64'(bus.locked), 64'd0);
      check("disable_gain", 64'(bus.gain), 64'd306);
      bus.enable = 1'b1;
      step();

      // Step down: err=-1000 -> delta=floor(-62.5)=-63
      pulse_update(16'd2000);
      check("gain_down", 64'(bus.gain), 64'd243);
      check("locked_after_down", 64'(bus.locked), 64'd0);
      exp_gain = 243;
      settle(32);

      // Minimum step: err=10 -> 10>>>4=0 forced to +1
      bus.ref_pow   = 16'd60;
      bus.tolerance = 16'd0;
      pulse_update(16'd50);
      check("gain_min_step", 64'(bus.gain), 64'd244);
      exp_gain = 244;
      settle(32);

      // Clamp high: 244+4095 -> 4096
      bus.ref_pow = 16'hFFFF;
      pulse_update(16'd0);
      check("gain_clamp_max", 64'(bus.gain), 64'd4096);
      exp_gain = 4096;
      settle(32);

      // Clamp low: 4096-4096=0 -> 16
      bus.ref_pow = 16'd0;
      pulse_update(16'hFFFF);
      check("gain_clamp_min", 64'(bus.gain), 64'd16);
      exp_gain = 16;
      settle(10);
      repeat (4) step();

      // Reset in the middle of SETTLE
      rst = 1'b0;
      bus.ref_pow = 16'd4296;
      step();
      check("rst_settle_gain", 64'(bus.gain), 64'd256);
      check("rst_settle_locked", 64'(bus.locked), 64'd0);
      rst = 1'b1;
      step();
      // A fresh measurement right away proves the loop left SETTLE: err=4096 -> delta=256
      pulse_update(16'd200);
      check("gain_after_rst", 64'(bus.gain), 64'd512);
      exp_gain = 512;

      // Saturation at gain 2.0
      send_beat({8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'h32, 8'h9C, 8'h64});
      send_beat({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'h32});
      settle(30);
      repeat (6) step();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
